// File: rtl/vram_pkg.sv
// Types and widths shared by the VRAM arbiter and its write buffer.
package vram_pkg;

    localparam int unsigned VRAM_AW = 15;
    localparam int unsigned VRAM_DW = 8;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_VID  = 2'd1,
        GRANT_WR   = 2'd2,
        GRANT_RD   = 2'd3
    } grant_t;

    typedef struct packed {
        logic [VRAM_AW-1:0] addr;
        logic [VRAM_DW-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Video-fetch and CPU request/response bundle between the clients and the VRAM arbiter.
interface vram_arbiter_if;
    import vram_pkg::*;

    logic               vid_req;
    logic [VRAM_AW-1:0] vid_addr;
    logic               vid_valid;
    logic [VRAM_DW-1:0] vid_data;

    logic               cpu_req;
    logic               cpu_we;
    logic [VRAM_AW-1:0] cpu_addr;
    logic [VRAM_DW-1:0] cpu_wdata;
    logic               cpu_ack;
    logic [VRAM_DW-1:0] cpu_rdata;

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  vid_valid, vid_data, cpu_ack, cpu_rdata
    );

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output vid_valid, vid_data, cpu_ack, cpu_rdata
    );
endinterface

// File: rtl/vram_wr_fifo.sv
// Synchronous CPU write buffer; DEPTH must be a power of two so the pointers wrap naturally.
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  wr_entry_t     push_data,
    input  logic          pop,
    output wr_entry_t     head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    wr_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign count   = count_q;

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: one slot per cycle between video fetch, buffered CPU writes and CPU reads.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    vram_arbiter_if.slave      bus,
    output logic [VRAM_AW-1:0] ram_addr,
    output logic [VRAM_DW-1:0] ram_wdata,
    output logic               ram_we,
    input  logic [VRAM_DW-1:0] ram_q
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    grant_t             grant_q;
    grant_t             grant_d;
    logic [SW-1:0]      starve_q;
    logic [VRAM_AW-1:0] vid_addr_q;
    logic               vid_valid_q;
    logic [VRAM_DW-1:0] vid_data_q;
    logic               cpu_ack_q;
    logic [VRAM_DW-1:0] cpu_rdata_q;

    wr_entry_t          wr_in;
    wr_entry_t          fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;

    logic               wr_accept;
    logic               rd_want;
    logic               vid_busy;
    logic               vid_want;
    logic               cpu_work;
    logic               forced;

    assign wr_in = '{addr: bus.cpu_addr, data: bus.cpu_wdata};

    // A request already acked, or a read already in flight, must not be taken again.
    assign wr_accept = bus.cpu_req & bus.cpu_we & ~cpu_ack_q & ~fifo_full;
    assign rd_want   = bus.cpu_req & ~bus.cpu_we & ~cpu_ack_q & (grant_q != GRANT_RD);
    // A held video address whose data is still on its way is the same request; a new address streams.
    assign vid_busy  = ((grant_q == GRANT_VID) | vid_valid_q) & (vid_addr_q == bus.vid_addr);
    assign vid_want  = bus.vid_req & ~vid_busy;
    assign cpu_work  = (fifo_count != '0) | rd_want;
    assign forced    = cpu_work & (starve_q == SW'(STARVE_LIMIT));

    vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (wr_accept),
        .push_data (wr_in),
        .pop       (grant_d == GRANT_WR),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Slot selection; reads wait for an empty buffer to keep read-after-write order.
    always_comb begin
        grant_d = GRANT_NONE;
        if (forced) begin
            grant_d = fifo_empty ? GRANT_RD : GRANT_WR;
        end else if (vid_want) begin
            grant_d = GRANT_VID;
        end else if (!fifo_empty) begin
            grant_d = GRANT_WR;
        end else if (rd_want) begin
            grant_d = GRANT_RD;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant_q <= GRANT_NONE;
        end else begin
            grant_q <= grant_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr    <= '0;
            ram_wdata   <= '0;
            ram_we      <= 1'b0;
            vid_addr_q  <= '0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            starve_q    <= '0;
        end else begin
            ram_we <= (grant_d == GRANT_WR);
            case (grant_d)
                GRANT_VID: begin
                    ram_addr   <= bus.vid_addr;
                    vid_addr_q <= bus.vid_addr;
                end
                GRANT_WR: begin
                    ram_addr  <= fifo_head.addr;
                    ram_wdata <= fifo_head.data;
                end
                GRANT_RD: ram_addr <= bus.cpu_addr;
                default: ;
            endcase

            vid_valid_q <= (grant_q == GRANT_VID);
            if (grant_q == GRANT_VID) vid_data_q <= ram_q;
            cpu_ack_q <= wr_accept | (grant_q == GRANT_RD);
            if (grant_q == GRANT_RD) cpu_rdata_q <= ram_q;

            // Count slots lost to video while the CPU has work; saturate at the limit.
            if ((grant_d == GRANT_VID) && cpu_work) begin
                if (starve_q != SW'(STARVE_LIMIT)) starve_q <= starve_q + SW'(1);
            end else begin
                starve_q <= '0;
            end
        end
    end

    assign bus.vid_valid = vid_valid_q;
    assign bus.vid_data  = vid_data_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;

endmodule
